// File: rtl/keccak_arbiter_if.sv
// Bus bundle between the keccak arbiter, its two message requesters and the
// keccak core. The slave modport is the arbiter's view (it serves the
// requesters and drives the core); the master modport is the view of the
// environment made of both requesters plus the core.
interface keccak_arbiter_if;
  // requester 0 channel
  logic         req0_valid;
  logic [63:0]  req0_data;
  logic         req0_last;
  logic [2:0]   req0_byte_num;
  logic         req0_ack;
  logic         req0_done;
  // requester 1 channel
  logic         req1_valid;
  logic [63:0]  req1_data;
  logic         req1_last;
  logic [2:0]   req1_byte_num;
  logic         req1_ack;
  logic         req1_done;
  // keccak core channel
  logic         core_reset;
  logic [63:0]  core_in;
  logic         core_in_ready;
  logic         core_is_last;
  logic [2:0]   core_byte_num;
  logic         core_buffer_full;
  logic [511:0] core_out;
  logic         core_out_ready;

  modport slave (
    input  req0_valid, req0_data, req0_last, req0_byte_num,
    output req0_ack, req0_done,
    input  req1_valid, req1_data, req1_last, req1_byte_num,
    output req1_ack, req1_done,
    output core_reset, core_in, core_in_ready, core_is_last, core_byte_num,
    input  core_buffer_full, core_out, core_out_ready
  );

  modport master (
    output req0_valid, req0_data, req0_last, req0_byte_num,
    input  req0_ack, req0_done,
    output req1_valid, req1_data, req1_last, req1_byte_num,
    input  req1_ack, req1_done,
    input  core_reset, core_in, core_in_ready, core_is_last, core_byte_num,
    output core_buffer_full, core_out, core_out_ready
  );
endinterface

// File: rtl/keccak_arbiter.sv
// Shares one keccak core between two message requesters, one whole message
// at a time. A requester is granted round-robin, its word stream is steered
// into the core under core back-pressure, the digest is latched with the
// owner id, the owner's done is pulsed, and the core is then held in reset
// for RESET_CYCLES so its sticky state clears before the next message.
module keccak_arbiter #(
  parameter int RESET_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  keccak_arbiter_if.slave bus,
  output logic [1:0]      grant,
  output logic [511:0]    digest,
  output logic            digest_id
);

  localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {CLR, IDLE, FEED, WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_id_q, last_id_d;
  logic [1:0]       done_q, done_d;
  logic             core_reset_q, core_reset_d;
  logic             capture;

  // steering of the granted requester onto the core
  logic             gid;
  logic             sel_valid;
  logic             sel_last;
  logic [63:0]      sel_data;
  logic [2:0]       sel_byte_num;
  logic             accept;

  // Select the granted requester's word; grant_q[1] doubles as the owner id.
  always_comb begin
    gid          = grant_q[1];
    sel_valid    = gid ? bus.req1_valid    : bus.req0_valid;
    sel_last     = gid ? bus.req1_last     : bus.req0_last;
    sel_data     = gid ? bus.req1_data     : bus.req0_data;
    sel_byte_num = gid ? bus.req1_byte_num : bus.req0_byte_num;
    accept       = (state_q == FEED) && sel_valid && !bus.core_buffer_full;
  end

  // The core sees the mux output unconditionally; in_ready qualifies it.
  assign bus.core_in       = sel_data;
  assign bus.core_byte_num = sel_byte_num;
  assign bus.core_in_ready = accept;
  assign bus.core_is_last  = accept && sel_last;
  assign bus.req0_ack      = accept && !gid;
  assign bus.req1_ack      = accept && gid;

  assign bus.core_reset    = core_reset_q;
  assign bus.req0_done     = done_q[0];
  assign bus.req1_done     = done_q[1];
  assign grant             = grant_q;

  // Next-state and registered-output decisions for the arbitration FSM.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    grant_d      = grant_q;
    last_id_d    = last_id_q;
    done_d       = 2'b00;
    core_reset_d = core_reset_q;
    capture      = 1'b0;
    unique case (state_q)
      CLR: begin
        if (clr_cnt_q == CNT_LAST) begin
          state_d      = IDLE;
          core_reset_d = 1'b0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (bus.req0_valid && bus.req1_valid) begin
          // contention: the requester not served last goes next
          grant_d = last_id_q ? 2'b01 : 2'b10;
          state_d = FEED;
        end else if (bus.req0_valid) begin
          grant_d = 2'b01;
          state_d = FEED;
        end else if (bus.req1_valid) begin
          grant_d = 2'b10;
          state_d = FEED;
        end
      end
      FEED: begin
        // a stalled or silent owner simply keeps the core; no timeout
        if (accept && sel_last) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.core_out_ready) begin
          capture      = 1'b1;
          done_d[gid]  = 1'b1;
          last_id_d    = gid;
          grant_d      = 2'b00;
          state_d      = CLR;
          clr_cnt_d    = '0;
          core_reset_d = 1'b1;
        end
      end
      default: begin
        state_d = CLR;
      end
    endcase
  end

  // Control state register; reset parks the core in reset with no owner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= CLR;
      clr_cnt_q    <= '0;
      grant_q      <= 2'b00;
      last_id_q    <= 1'b1;
      done_q       <= 2'b00;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      grant_q      <= grant_d;
      last_id_q    <= last_id_d;
      done_q       <= done_d;
      core_reset_q <= core_reset_d;
    end
  end

  // Digest holding register; loads only when a message completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digest    <= '0;
      digest_id <= 1'b0;
    end else if (capture) begin
      digest    <= bus.core_out;
      digest_id <= gid;
    end
  end

endmodule

// File: tb/tb_keccak_arbiter.sv
// Directed bench for keccak_arbiter: the bench plays both requesters and the
// keccak core, and checks grants, steering, back-pressure, digest capture,
// done pulses and the core reset window against hand-computed values.
module tb_keccak_arbiter;

  logic         clk;
  logic         reset;
  logic [1:0]   grant;
  logic [511:0] digest;
  logic         digest_id;
  int           total;
  int           bad;
  int           accepts;

  keccak_arbiter_if bus();

  keccak_arbiter #(.RESET_CYCLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .grant     (grant),
    .digest    (digest),
    .digest_id (digest_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Called while the arbiter sits in WAIT: the modelled core raises its digest,
  // then the capture, done pulse and two-cycle core reset are checked, ending
  // at the middle of the first IDLE cycle.
  task automatic finish_msg(input logic id, input logic [511:0] dig);
    bus.core_out       = dig;
    bus.core_out_ready = 1'b1;
    mid();
    chk("wait_in_ready", 512'(bus.core_in_ready), 512'(0));
    chk("wait_no_done", 512'({bus.req1_done, bus.req0_done}), 512'(0));
    nxt();
    bus.core_out_ready = 1'b0;
    mid();
    chk("digest", digest, dig);
    chk("digest_id", 512'(digest_id), 512'(id));
    chk("done_pulse", 512'({bus.req1_done, bus.req0_done}), id ? 512'(2) : 512'(1));
    chk("grant_released", 512'(grant), 512'(0));
    chk("core_reset_1", 512'(bus.core_reset), 512'(1));
    nxt();
    mid();
    chk("done_cleared", 512'({bus.req1_done, bus.req0_done}), 512'(0));
    chk("core_reset_2", 512'(bus.core_reset), 512'(1));
    nxt();
    mid();
    chk("core_reset_off", 512'(bus.core_reset), 512'(0));
  endtask

  // Pulse reset from mid-IDLE and return at the middle of the next IDLE cycle.
  task automatic do_reset();
    nxt();
    reset = 1'b0;
    #1;
    chk("rst_core_reset", 512'(bus.core_reset), 512'(1));
    nxt();
    reset = 1'b1;
    mid();
    nxt();
    mid();
    nxt();
    mid();
    chk("rst_release_idle", 512'(bus.core_reset), 512'(0));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    accepts = 0;
    reset = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_last = 1'b0; bus.req0_byte_num = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_last = 1'b0; bus.req1_byte_num = '0;
    bus.core_buffer_full = 1'b0;
    bus.core_out = '0;
    bus.core_out_ready = 1'b0;

    // 1: reset held for 3 cycles, core reset held 2 cycles after release
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("t1_core_reset_in_rst", 512'(bus.core_reset), 512'(1));
      chk("t1_grant_in_rst", 512'(grant), 512'(0));
    end
    nxt();
    reset = 1'b1;
    mid();
    chk("t1_core_reset_rel0", 512'(bus.core_reset), 512'(1));
    nxt();
    mid();
    chk("t1_core_reset_rel1", 512'(bus.core_reset), 512'(1));
    nxt();
    mid();
    chk("t1_core_reset_idle", 512'(bus.core_reset), 512'(0));
    chk("t1_grant_idle", 512'(grant), 512'(0));
    chk("t1_in_ready_idle", 512'(bus.core_in_ready), 512'(0));
    chk("t1_digest_rst", digest, 512'(0));
    chk("t1_digest_id_rst", 512'(digest_id), 512'(0));

    // 2: req0 single-word message "abc"
    bus.req0_valid = 1'b1; bus.req0_data = 64'h6162630000000000;
    bus.req0_last = 1'b1; bus.req0_byte_num = 3'd3;
    #1;
    chk("t2_idle_no_ack", 512'(bus.req0_ack), 512'(0));
    nxt();
    mid();
    chk("t2_grant", 512'(grant), 512'(1));
    chk("t2_in_ready", 512'(bus.core_in_ready), 512'(1));
    chk("t2_ack", 512'(bus.req0_ack), 512'(1));
    chk("t2_is_last", 512'(bus.core_is_last), 512'(1));
    chk("t2_core_in", 512'(bus.core_in), 512'(64'h6162630000000000));
    chk("t2_byte_num", 512'(bus.core_byte_num), 512'(3));
    nxt();
    bus.req0_valid = 1'b0; bus.req0_last = 1'b0;
    finish_msg(1'b0, {8{64'h0123456789abcdef}});

    // 3: both requesters always valid after a fresh reset -> 0, 1, 0
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_data = 64'hA0A0A0A0A0A0A0A0;
    bus.req0_last = 1'b1; bus.req0_byte_num = 3'd7;
    bus.req1_valid = 1'b1; bus.req1_data = 64'hB0B0B0B0B0B0B0B0;
    bus.req1_last = 1'b1; bus.req1_byte_num = 3'd1;
    for (int k = 0; k < 3; k++) begin
      nxt();
      mid();
      chk("t3_grant", 512'(grant), (k == 1) ? 512'(2) : 512'(1));
      chk("t3_core_in", 512'(bus.core_in),
          (k == 1) ? 512'(64'hB0B0B0B0B0B0B0B0) : 512'(64'hA0A0A0A0A0A0A0A0));
      chk("t3_other_ack", 512'((k == 1) ? bus.req0_ack : bus.req1_ack), 512'(0));
      nxt();
      finish_msg(k == 1, {16{32'h00001000 + 32'(k)}});
    end
    bus.req0_valid = 1'b0; bus.req0_last = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_last = 1'b0;

    // 4: req1 three words with a 5-cycle core stall on word 2
    bus.req1_valid = 1'b1; bus.req1_data = 64'h1111111111111111;
    bus.req1_last = 1'b0; bus.req1_byte_num = 3'd0;
    nxt();
    mid();
    chk("t4_grant", 512'(grant), 512'(2));
    chk("t4_w1_is_last", 512'(bus.core_is_last), 512'(0));
    if (bus.req1_ack) accepts++;
    nxt();
    bus.req1_data = 64'h2222222222222222;
    bus.core_buffer_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("t4_stall_ack", 512'(bus.req1_ack), 512'(0));
      chk("t4_stall_in_ready", 512'(bus.core_in_ready), 512'(0));
      chk("t4_stall_is_last", 512'(bus.core_is_last), 512'(0));
      if (bus.req1_ack) accepts++;
      nxt();
    end
    bus.core_buffer_full = 1'b0;
    mid();
    chk("t4_w2_ack", 512'(bus.req1_ack), 512'(1));
    chk("t4_w2_core_in", 512'(bus.core_in), 512'(64'h2222222222222222));
    chk("t4_w2_is_last", 512'(bus.core_is_last), 512'(0));
    if (bus.req1_ack) accepts++;
    nxt();
    bus.req1_data = 64'h3333333333333333;
    bus.req1_last = 1'b1; bus.req1_byte_num = 3'd5;
    mid();
    chk("t4_w3_ack", 512'(bus.req1_ack), 512'(1));
    chk("t4_w3_is_last", 512'(bus.core_is_last), 512'(1));
    chk("t4_w3_byte_num", 512'(bus.core_byte_num), 512'(5));
    if (bus.req1_ack) accepts++;
    nxt();
    bus.req1_valid = 1'b0; bus.req1_last = 1'b0;
    chk("t4_accepts", 512'(accepts), 512'(3));
    finish_msg(1'b1, {8{64'hfedcba9876543210}});

    // 5: req1 waits through a two-word req0 message with a gap in it
    bus.req0_valid = 1'b1; bus.req0_data = 64'hC1C1C1C1C1C1C1C1;
    bus.req0_last = 1'b0; bus.req0_byte_num = 3'd0;
    bus.req1_valid = 1'b1; bus.req1_data = 64'hE1E1E1E1E1E1E1E1;
    bus.req1_last = 1'b1; bus.req1_byte_num = 3'd2;
    nxt();
    mid();
    chk("t5_grant0", 512'(grant), 512'(1));
    chk("t5_w1_ack0", 512'(bus.req0_ack), 512'(1));
    chk("t5_w1_ack1", 512'(bus.req1_ack), 512'(0));
    chk("t5_w1_core_in", 512'(bus.core_in), 512'(64'hC1C1C1C1C1C1C1C1));
    nxt();
    bus.req0_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mid();
      chk("t5_gap_in_ready", 512'(bus.core_in_ready), 512'(0));
      chk("t5_gap_ack1", 512'(bus.req1_ack), 512'(0));
      chk("t5_gap_grant", 512'(grant), 512'(1));
      nxt();
    end
    bus.req0_valid = 1'b1; bus.req0_data = 64'hC2C2C2C2C2C2C2C2;
    bus.req0_last = 1'b1; bus.req0_byte_num = 3'd4;
    mid();
    chk("t5_w2_ack0", 512'(bus.req0_ack), 512'(1));
    chk("t5_w2_ack1", 512'(bus.req1_ack), 512'(0));
    chk("t5_w2_is_last", 512'(bus.core_is_last), 512'(1));
    chk("t5_w2_core_in", 512'(bus.core_in), 512'(64'hC2C2C2C2C2C2C2C2));
    nxt();
    bus.req0_valid = 1'b0; bus.req0_last = 1'b0;
    finish_msg(1'b0, {8{64'h5a5a5a5a00000005}});
    nxt();
    mid();
    chk("t5_grant1", 512'(grant), 512'(2));
    chk("t5_r1_ack", 512'(bus.req1_ack), 512'(1));
    chk("t5_r1_core_in", 512'(bus.core_in), 512'(64'hE1E1E1E1E1E1E1E1));
    chk("t5_r1_byte_num", 512'(bus.core_byte_num), 512'(2));
    nxt();
    bus.req1_valid = 1'b0; bus.req1_last = 1'b0;
    finish_msg(1'b1, {8{64'h6b6b6b6b00000006}});

    // 6: reset during WAIT abandons the message; the next one completes
    bus.req0_valid = 1'b1; bus.req0_data = 64'hF1F1F1F1F1F1F1F1;
    bus.req0_last = 1'b1; bus.req0_byte_num = 3'd0;
    nxt();
    mid();
    chk("t6_grant0", 512'(grant), 512'(1));
    nxt();
    bus.req0_valid = 1'b0; bus.req0_last = 1'b0;
    bus.core_out = {8{64'h7777777777777777}};
    mid();
    chk("t6_wait_in_ready", 512'(bus.core_in_ready), 512'(0));
    reset = 1'b0;
    #1;
    chk("t6_rst_grant", 512'(grant), 512'(0));
    chk("t6_rst_core_reset", 512'(bus.core_reset), 512'(1));
    bus.core_out_ready = 1'b1;
    nxt();
    mid();
    chk("t6_rst_no_done", 512'({bus.req1_done, bus.req0_done}), 512'(0));
    chk("t6_rst_digest", digest, 512'(0));
    nxt();
    reset = 1'b1;
    bus.core_out_ready = 1'b0;
    mid();
    chk("t6_rel_core_reset0", 512'(bus.core_reset), 512'(1));
    chk("t6_rel_no_done", 512'({bus.req1_done, bus.req0_done}), 512'(0));
    nxt();
    mid();
    chk("t6_rel_core_reset1", 512'(bus.core_reset), 512'(1));
    nxt();
    mid();
    chk("t6_rel_idle", 512'(bus.core_reset), 512'(0));
    bus.req1_valid = 1'b1; bus.req1_data = 64'h9999999999999999;
    bus.req1_last = 1'b1; bus.req1_byte_num = 3'd6;
    nxt();
    mid();
    chk("t6_grant1", 512'(grant), 512'(2));
    chk("t6_r1_ack", 512'(bus.req1_ack), 512'(1));
    chk("t6_r1_byte_num", 512'(bus.core_byte_num), 512'(6));
    nxt();
    bus.req1_valid = 1'b0; bus.req1_last = 1'b0;
    finish_msg(1'b1, {8{64'h8888888800000008}});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
